// File: rtl/mux_pkg.sv
// Shared definitions for the multiplex_stream_n stream multiplexer.
package mux_pkg;

  // Encodings of the modo input
  localparam logic MODO_EXPLICITO = 1'b0;
  localparam logic MODO_RR        = 1'b1;

  // Width of a channel index; at least one bit even for tiny N
  function automatic int idx_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// searching upward from ptr+1, wrapping modulo N. Used only when the
// multiplexer is built with MUX_RR_EN.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Rotating priority search starting just after the last winner
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(cand);
      end
    end
  end

endmodule

// File: rtl/multiplex_stream_n.sv
// N-channel registered stream multiplexer with valid/ready handshakes and
// multi-beat packet locking. Channel selection is by explicit control index,
// or by round-robin arbitration when built with `define MUX_RR_EN (which adds
// the modo port and the ptr register). Without MUX_RR_EN it is explicit-only.
module multiplex_stream_n
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int CW = idx_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic [CW-1:0]  control,
`ifdef MUX_RR_EN
  input  logic           modo,
`endif
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [CW-1:0]  out_chan,
  input  logic           out_ready
);

  logic          lock;
  logic [CW-1:0] lock_chan;
  logic          load_en;
  logic          ctrl_ok;
  logic          gnt_any;
  logic [CW-1:0] gnt_idx;
  logic          xfer;
  logic [W-1:0]  sel_data;
  logic          sel_last;

  // The single output register may take a new beat when empty or draining
  assign load_en = !out_valid || out_ready;
  // control can exceed N-1 when N is not a power of two
  assign ctrl_ok = int'(control) < N;

`ifdef MUX_RR_EN
  logic [CW-1:0] ptr;
  logic [CW-1:0] rr_idx;
  logic          rr_any;

  rr_arbiter #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );
`endif

  // Grant selection: an open packet pins the channel, otherwise mode decides
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (lock) begin
      gnt_any = 1'b1;
      gnt_idx = lock_chan;
    end
`ifdef MUX_RR_EN
    else if (modo == MODO_RR) begin
      gnt_any = rr_any;
      gnt_idx = rr_idx;
    end
`endif
    else if (ctrl_ok) begin
      gnt_any = 1'b1;
      gnt_idx = control;
    end
  end

  // One-hot ready towards the granted producer; silent during reset
  always_comb begin
    in_ready = '0;
    if (!rst && load_en && gnt_any) in_ready[gnt_idx] = 1'b1;
  end

  assign xfer     = |(in_valid & in_ready);
  assign sel_data = in_data[gnt_idx*W +: W];
  assign sel_last = in_last[gnt_idx];

  // Output register: load on transfer, empty on drain, hold under backpressure
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_chan <= gnt_idx;
      end
    end
  end

  // Packet lock and round-robin pointer; a whole packet is one turn
  always_ff @(posedge clk) begin
    if (rst) begin
      lock      <= 1'b0;
      lock_chan <= '0;
`ifdef MUX_RR_EN
      ptr       <= CW'(N - 1);
`endif
    end else if (xfer) begin
      lock <= !sel_last;
      if (!sel_last) lock_chan <= gnt_idx;
`ifdef MUX_RR_EN
      if (sel_last) ptr <= gnt_idx;
`endif
    end
  end

endmodule

// File: tb/tb_multiplex_stream_n.sv
// Self-checking bench for multiplex_stream_n: directed vector table, hand
// sequences for backpressure / lock / mid-packet reset / out-of-range control,
// round-robin sequences when MUX_RR_EN is defined, then randomized traffic
// against a behavioural model.
module tb_multiplex_stream_n;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam int N5 = 5;
  localparam int W5 = 8;
  localparam int C5 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic [CW-1:0]  control = '0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [CW-1:0]  out_chan;
  logic           out_ready = 1'b1;
  bit             rr_mode = 1'b0;

  logic [N5*W5-1:0] d5_data = '0;
  logic [N5-1:0]    d5_valid = '0;
  logic [N5-1:0]    d5_last = '0;
  logic [N5-1:0]    d5_ready;
  logic [C5-1:0]    d5_control = '0;
  logic [W5-1:0]    d5_out_data;
  logic             d5_out_valid;
  logic             d5_out_last;
  logic [C5-1:0]    d5_out_chan;
  logic             d5_out_ready = 1'b1;

  multiplex_stream_n #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .control   (control),
`ifdef MUX_RR_EN
    .modo      (rr_mode),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  // Five channels: a 3-bit control can name indices 5..7 that do not exist
  multiplex_stream_n #(.N(N5), .W(W5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d5_data),
    .in_valid  (d5_valid),
    .in_last   (d5_last),
    .in_ready  (d5_ready),
    .control   (d5_control),
`ifdef MUX_RR_EN
    .modo      (1'b0),
`endif
    .out_data  (d5_out_data),
    .out_valid (d5_out_valid),
    .out_last  (d5_out_last),
    .out_chan  (d5_out_chan),
    .out_ready (d5_out_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic ol,
                           input logic [CW-1:0] oc, input logic [W-1:0] od);
    check({tag, "_out_valid"}, out_valid, ov);
    check({tag, "_out_last"},  out_last,  ol);
    check({tag, "_out_chan"},  out_chan,  oc);
    check({tag, "_out_data"},  out_data,  od);
  endtask

  // Reset both DUTs; in_ready must be zero while rst is high
  task automatic do_reset(input string tag);
    in_valid = '0;
    d5_valid = '0;
    control  = 2'd2;
    rst      = 1'b1;
    @(negedge clk);
    check({tag, "_ready_in_rst"}, in_ready, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_out({tag, "_rst"}, 1'b0, 1'b0, '0, '0);
    check({tag, "_d5_valid_rst"}, d5_out_valid, 1'b0);
    tick();
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [CW-1:0] ctrl;
    logic          ordy;
    logic [N-1:0]  rdy;
    logic          ov;
    logic          ol;
    logic [CW-1:0] oc;
    logic [W-1:0]  od;
  } vec_t;

  vec_t tbl [15];

  // Behavioural reference state
  int            m_ptr;
  bit            m_lock;
  int            m_lock_chan;
  logic          m_ov;
  logic          m_ol;
  logic [CW-1:0] m_oc;
  logic [W-1:0]  m_od;

  function automatic int model_grant();
    if (m_lock) return m_lock_chan;
    if (rr_mode) begin
      for (int k = 1; k <= N; k++)
        if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
    end
    return (int'(control) < N) ? int'(control) : -1;
  endfunction

`ifdef MUX_RR_EN
  logic [N-1:0] rr_rdy_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int           rr_chn_a [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] rr_rdy_b [3] = '{4'b0010, 4'b1000, 4'b0010};
  int           rr_chn_b [3] = '{1, 3, 1};
`endif

  initial begin
    // valid, last, ctrl, out_ready | in_ready, out_valid, out_last, out_chan, out_data
    tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[7]  = '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd2, 32'hCAFE0002};
    tbl[8]  = '{4'b1010, 4'b0000, 2'd3, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 32'hCAFE0001};
    tbl[9]  = '{4'b1010, 4'b0010, 2'd3, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 32'hCAFE0001};
    tbl[10] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd1, 32'hCAFE0001};
    tbl[11] = '{4'b0000, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 32'hCAFE0003};
    tbl[12] = '{4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd3, 32'hCAFE0003};
    tbl[13] = '{4'b0101, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 32'hCAFE0000};
    tbl[14] = '{4'b0101, 4'b0000, 2'd2, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 32'hCAFE0000};

    for (int ch = 0; ch < N; ch++) in_data[ch*W +: W] = 32'hCAFE0000 + 32'(ch);
    for (int ch = 0; ch < N5; ch++) d5_data[ch*W5 +: W5] = 8'hA0 + 8'(ch);

    // Directed table: explicit grant, backpressure, packet lock
    do_reset("init");
    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i].valid;
      in_last   = tbl[i].last;
      control   = tbl[i].ctrl;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("row%0d_in_ready", i), in_ready, tbl[i].rdy);
      check_out($sformatf("row%0d", i), tbl[i].ov, tbl[i].ol, tbl[i].oc, tbl[i].od);
      tick();
    end

    // Reset while channel 0 holds a lock: lock and held beat are dropped
    rst = 1'b1; in_valid = 4'b0101; in_last = 4'b0100; control = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_ready", in_ready, 4'b0000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", in_ready, 4'b0100);
    check_out("postrst", 1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    in_valid = '0;
    @(negedge clk);
    check_out("postrst_beat", 1'b1, 1'b1, 2'd2, 32'hCAFE0002);
    tick();

    // Out-of-range control on the five-channel instance
    do_reset("d5");
    d5_valid = '1; d5_last = '1; d5_out_ready = 1'b1;
    for (int c = 5; c < 8; c++) begin
      d5_control = C5'(c);
      @(negedge clk);
      check($sformatf("d5_ctrl%0d_ready", c), d5_ready, '0);
      check($sformatf("d5_ctrl%0d_valid", c), d5_out_valid, 1'b0);
      tick();
    end
    d5_control = 3'd4;
    @(negedge clk);
    check("d5_ctrl4_ready", d5_ready, 5'b10000);
    tick();
    d5_valid = '0;
    @(negedge clk);
    check("d5_ctrl4_valid", d5_out_valid, 1'b1);
    check("d5_ctrl4_chan", d5_out_chan, 3'd4);
    check("d5_ctrl4_data", d5_out_data, 8'hA4);
    check("d5_ctrl4_last", d5_out_last, 1'b1);
    tick();

`ifdef MUX_RR_EN
    // Round robin, all channels valid, single-beat packets
    do_reset("rr_all");
    rr_mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) check($sformatf("rr_all%0d_ready", k), in_ready, rr_rdy_a[k]);
      if (k > 0) begin
        check($sformatf("rr_all%0d_valid", k), out_valid, 1'b1);
        check($sformatf("rr_all%0d_chan", k), out_chan, CW'(rr_chn_a[k-1]));
      end
      tick();
    end
    // Round robin, only channels 1 and 3 valid
    do_reset("rr_13");
    in_valid = 4'b1010;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) check($sformatf("rr_13_%0d_ready", k), in_ready, rr_rdy_b[k]);
      if (k > 0) check($sformatf("rr_13_%0d_chan", k), out_chan, CW'(rr_chn_b[k-1]));
      tick();
    end
    rr_mode = 1'b0;
`endif

    // Randomized traffic against the behavioural model
    for (int cyc = 0; cyc < 800; cyc++) begin
      int            g;
      logic          load;
      logic [N-1:0]  exp_rdy;
      rst       = (cyc == 0) || ($urandom_range(0, 79) == 0);
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      control   = CW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_EN
      rr_mode   = ($urandom_range(0, 1) == 1);
`endif
      for (int ch = 0; ch < N; ch++) in_data[ch*W +: W] = $urandom;
      @(negedge clk);
      if (cyc > 0) begin
        g       = model_grant();
        load    = !m_ov || out_ready;
        exp_rdy = (!rst && load && g >= 0) ? (N'(1) << g) : '0;
        check($sformatf("rnd%0d_ready", cyc), in_ready, exp_rdy);
        check_out($sformatf("rnd%0d", cyc), m_ov, m_ol, m_oc, m_od);
      end else begin
        g       = -1;
        load    = 1'b0;
        exp_rdy = '0;
        check("rnd0_ready_in_rst", in_ready, '0);
      end
      if (rst) begin
        m_ptr = N - 1; m_lock = 1'b0; m_lock_chan = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_oc = '0; m_od = '0;
      end else if (load) begin
        m_ov = (exp_rdy != '0) && in_valid[g];
        if (m_ov) begin
          m_od   = in_data[g*W +: W];
          m_ol   = in_last[g];
          m_oc   = CW'(g);
          m_lock = !in_last[g];
          if (!in_last[g]) m_lock_chan = g;
          else             m_ptr = g;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
